// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline hazard/stall controller with the mult/div busy counter.
// Optional STALL_CTRL_PERF_EN adds free-running stall and md-stall cycle counters.
module stall_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rsAddr,
  input  logic [4:0]  D_rtAddr,
  input  logic [1:0]  D_rsTuse,
  input  logic [1:0]  D_rtTuse,
  input  logic        D_isMD,
  input  logic [4:0]  E_wAddr,
  input  logic [1:0]  E_Tnew,
  input  logic        E_mdStart,
  input  logic        E_mdOp,
  input  logic [4:0]  M_wAddr,
  input  logic [1:0]  M_Tnew,
`ifdef STALL_CTRL_PERF_EN
  output logic [31:0] stallCnt,
  output logic [31:0] mdStallCnt,
`endif
  output logic        stall,
  output logic        pcEn,
  output logic        fdEn,
  output logic        deClr,
  output logic        mdBusy
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rs_e, rs_m, rt_e, rt_m, data_stall, md_stall;
  always_comb begin
    rs_e       = (D_rsAddr != 5'd0) && (D_rsAddr == E_wAddr) && (E_Tnew > D_rsTuse);
    rs_m       = (D_rsAddr != 5'd0) && (D_rsAddr == M_wAddr) && (M_Tnew > D_rsTuse);
    rt_e       = (D_rtAddr != 5'd0) && (D_rtAddr == E_wAddr) && (E_Tnew > D_rtTuse);
    rt_m       = (D_rtAddr != 5'd0) && (D_rtAddr == M_wAddr) && (M_Tnew > D_rtTuse);
    data_stall = rs_e || rs_m || rt_e || rt_m;
    mdBusy     = cnt_q != '0;
    md_stall   = D_isMD && (mdBusy || E_mdStart);
    stall      = (data_stall || md_stall) && !reset;
    pcEn       = !stall;
    fdEn       = !stall;
    deClr      = stall;
    // a new start reloads even while busy; otherwise count down and saturate at 0
    cnt_d      = E_mdStart ? (E_mdOp ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT))
                           : (mdBusy ? cnt_q - 1'b1 : cnt_q);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
`ifdef STALL_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, md_cnt_q, md_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    md_cnt_d    = md_cnt_q + {31'd0, md_stall};
    stallCnt    = stall_cnt_q;
    mdStallCnt  = md_cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stall_cnt_q <= '0;
      md_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      md_cnt_q    <= md_cnt_d;
    end
`endif
endmodule
